// File: rtl/decode_stall_ctl.sv
// Decode-stage sequencing controller: load-use interlock, syscall drain/handoff,
// and drained SETR label commit. Owns the registered ReadLabel/WriteLabel state.
module decode_stall_ctl #(
  parameter int unsigned DRAIN = 2
) (
  input  logic       CLK,
  input  logic       MRST_N,
  input  logic       I1Valid,
  input  logic       instIsSyscall,
  input  logic [4:0] RSaddr,
  input  logic [4:0] RTaddr,
  input  logic       ExLoad,
  input  logic [4:0] ExRDaddr,
  input  logic       SetrValid,
  input  logic       SetrLabel,
  input  logic       SysDone,
  output logic       Stall,
  output logic       Bubble,
  output logic       SysReq,
  output logic       ReadLabel,
  output logic       WriteLabel
);

  typedef enum logic [2:0] {
    RUN,
    SYS_DRAIN,
    SYS_REQ,
    SYS_REL,
    LBL_DRAIN
  } state_t;

  // The detecting cycle in RUN/SYS_REL is the first drain cycle, so with
  // DRAIN==1 the drain states are bypassed entirely.
  localparam logic       SKIP_DRAIN = (DRAIN == 1);
  localparam logic [1:0] LAST_CNT   = 2'(DRAIN - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic [1:0] w_cnt_inc;
  logic       r_pend;
  logic       w_pend_nxt;
  logic       w_commit;
  logic       w_hazard;
  logic       w_syscall;
  logic       w_drain_done;

  assign w_hazard     = I1Valid & ExLoad & (ExRDaddr != 5'd0) &
                        ((ExRDaddr == RSaddr) | (ExRDaddr == RTaddr));
  assign w_syscall    = I1Valid & instIsSyscall;
  assign w_cnt_inc    = r_cnt + 2'd1;
  assign w_drain_done = (w_cnt_inc == LAST_CNT);

  always_ff @(posedge CLK or negedge MRST_N) begin
    if (!MRST_N) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_ff @(posedge CLK or negedge MRST_N) begin
    if (!MRST_N) begin
      ReadLabel  <= 1'b0;
      WriteLabel <= 1'b0;
    end else if (w_commit) begin
      ReadLabel  <= w_pend_nxt;
      WriteLabel <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_commit    = 1'b0;
    unique case (r_state)
      RUN, SYS_REL: begin
        if (SetrValid) begin
          w_pend_nxt = SetrLabel;
          w_cnt_nxt  = '0;
          if (SKIP_DRAIN) begin
            w_commit    = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = LBL_DRAIN;
          end
        end else if ((r_state == RUN) && w_syscall) begin
          w_cnt_nxt   = '0;
          w_state_nxt = SKIP_DRAIN ? SYS_REQ : SYS_DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      SYS_DRAIN: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_drain_done) begin
          w_state_nxt = SYS_REQ;
        end
      end
      SYS_REQ: begin
        if (SysDone) begin
          w_state_nxt = SYS_REL;
        end
      end
      LBL_DRAIN: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_drain_done) begin
          w_commit    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_comb begin
    Stall  = 1'b0;
    SysReq = 1'b0;
    unique case (r_state)
      RUN:       Stall = SetrValid | w_syscall | w_hazard;
      SYS_DRAIN: Stall = 1'b1;
      SYS_REQ: begin
        Stall  = 1'b1;
        SysReq = ~SysDone;
      end
      SYS_REL:   Stall = SetrValid;
      LBL_DRAIN: Stall = 1'b1;
      default:   Stall = 1'b0;
    endcase
    Bubble = Stall;
  end

endmodule

// File: tb/tb_decode_stall_ctl.sv
// Bench for decode_stall_ctl: directed literal checks plus randomized stimulus
// compared every cycle against a countdown-style behavioural model.
module tb_decode_stall_ctl;

  localparam int unsigned DRAIN = 2;

  logic       CLK = 1'b0;
  logic       MRST_N;
  logic       I1Valid;
  logic       instIsSyscall;
  logic [4:0] RSaddr;
  logic [4:0] RTaddr;
  logic       ExLoad;
  logic [4:0] ExRDaddr;
  logic       SetrValid;
  logic       SetrLabel;
  logic       SysDone;
  logic       Stall;
  logic       Bubble;
  logic       SysReq;
  logic       ReadLabel;
  logic       WriteLabel;

  int errors = 0;
  int checks = 0;

  decode_stall_ctl #(.DRAIN(DRAIN)) dut (
    .CLK          (CLK),
    .MRST_N       (MRST_N),
    .I1Valid      (I1Valid),
    .instIsSyscall(instIsSyscall),
    .RSaddr       (RSaddr),
    .RTaddr       (RTaddr),
    .ExLoad       (ExLoad),
    .ExRDaddr     (ExRDaddr),
    .SetrValid    (SetrValid),
    .SetrLabel    (SetrLabel),
    .SysDone      (SysDone),
    .Stall        (Stall),
    .Bubble       (Bubble),
    .SysReq       (SysReq),
    .ReadLabel    (ReadLabel),
    .WriteLabel   (WriteLabel)
  );

  always #5 CLK = ~CLK;

  // Model: remaining forced-bubble cycles, waiting-for-emulator flag,
  // one-cycle "just released" flag, and the label value.
  int m_left  = 0;
  bit m_lbl   = 0;
  bit m_wait  = 0;
  bit m_rel   = 0;
  bit m_pend  = 0;
  bit m_label = 0;

  function automatic void m_exp(output bit st, output bit sr);
    bit hz;
    hz = I1Valid && ExLoad && (ExRDaddr != 0) &&
         ((ExRDaddr == RSaddr) || (ExRDaddr == RTaddr));
    sr = 0;
    if (m_left > 0) st = 1;
    else if (m_wait) begin
      st = 1;
      sr = !SysDone;
    end else st = SetrValid || (!m_rel && ((I1Valid && instIsSyscall) || hz));
  endfunction

  task automatic m_finish_drain();
    if (m_lbl) begin
      m_label = m_pend;
      m_lbl   = 0;
    end else m_wait = 1;
  endtask

  task automatic m_start(bit is_lbl);
    m_lbl  = is_lbl;
    m_left = DRAIN - 1;
    if (m_left == 0) m_finish_drain();
  endtask

  initial forever begin
    @(posedge CLK or negedge MRST_N);
    if (!MRST_N) begin
      m_left = 0; m_lbl = 0; m_wait = 0; m_rel = 0; m_pend = 0; m_label = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_finish_drain();
    end else if (m_wait) begin
      if (SysDone) begin
        m_wait = 0;
        m_rel  = 1;
      end
    end else begin
      bit may_trap;
      may_trap = !m_rel;
      m_rel = 0;
      if (SetrValid) begin
        m_pend = SetrLabel;
        m_start(1);
      end else if (may_trap && I1Valid && instIsSyscall) begin
        m_start(0);
      end
    end
  end

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  initial forever begin
    bit st, sr;
    @(negedge CLK);
    m_exp(st, sr);
    chk("model_stall",  Stall,      st);
    chk("model_bubble", Bubble,     st);
    chk("model_sysreq", SysReq,     sr);
    chk("model_rlabel", ReadLabel,  m_label);
    chk("model_wlabel", WriteLabel, m_label);
  end

  task automatic idle();
    I1Valid = 0; instIsSyscall = 0; RSaddr = '0; RTaddr = '0; ExLoad = 0;
    ExRDaddr = '0; SetrValid = 0; SetrLabel = 0; SysDone = 0;
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  // Literal expectation for the current cycle; also pins the model.
  task automatic expect5(input string nm, input bit s, input bit r, input bit l);
    bit mst, msr;
    @(negedge CLK);
    #1;
    chk({nm, "_stall"},  Stall,      s);
    chk({nm, "_bubble"}, Bubble,     s);
    chk({nm, "_sysreq"}, SysReq,     r);
    chk({nm, "_rlabel"}, ReadLabel,  l);
    chk({nm, "_wlabel"}, WriteLabel, l);
    m_exp(mst, msr);
    chk({nm, "_pin_stall"}, mst, s);
    chk({nm, "_pin_label"}, m_label, l);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    MRST_N = 0;
    idle();
    expect5("reset", 0, 0, 0);
    next();
    MRST_N = 1;

    // load-use via RS, via RT, and ExRDaddr==0
    I1Valid = 1; ExLoad = 1; ExRDaddr = 5'd5; RSaddr = 5'd5;
    expect5("lu_rs", 1, 0, 0);
    next(); ExLoad = 0;
    expect5("lu_after", 0, 0, 0);
    next(); ExLoad = 1; ExRDaddr = 5'd7; RSaddr = 5'd3; RTaddr = 5'd7;
    expect5("lu_rt", 1, 0, 0);
    next(); ExRDaddr = 5'd0; RSaddr = 5'd0; RTaddr = 5'd0;
    expect5("lu_r0", 0, 0, 0);

    // syscall with SysDone at cycle 6
    next(); idle(); I1Valid = 1; instIsSyscall = 1;
    for (int c = 0; c <= 8; c++) begin
      SysDone = (c == 6);
      if (c == 8) idle();
      expect5($sformatf("sys_c%0d", c), c <= 6, (c >= 2) && (c <= 5), 0);
      next();
    end

    // label to 1, then back to 0
    idle(); SetrValid = 1; SetrLabel = 1;
    expect5("lbl1_c0", 1, 0, 0);
    next(); SetrValid = 0;
    expect5("lbl1_c1", 1, 0, 0);
    next();
    expect5("lbl1_c2", 0, 0, 1);
    next(); SetrValid = 1; SetrLabel = 0;
    expect5("lbl0_c0", 1, 0, 1);
    next(); SetrValid = 0;
    expect5("lbl0_c1", 1, 0, 1);
    next();
    expect5("lbl0_c2", 0, 0, 0);

    // SETR in stage 3 together with syscall in stage 2
    next(); SetrValid = 1; SetrLabel = 1; I1Valid = 1; instIsSyscall = 1;
    for (int c = 0; c <= 7; c++) begin
      if (c == 1) SetrValid = 0;
      SysDone = (c == 5);
      if (c == 7) idle();
      expect5($sformatf("sim_c%0d", c), c <= 5, c == 4, c >= 2);
      next();
    end

    // spurious SysDone in RUN
    idle(); SysDone = 1;
    expect5("spur_c0", 0, 0, 1);
    next(); SysDone = 0;
    expect5("spur_c1", 0, 0, 1);

    // async reset while in SYS_REQ, labels currently 1
    next(); I1Valid = 1; instIsSyscall = 1;
    expect5("rst_c0", 1, 0, 1);
    next();
    expect5("rst_c1", 1, 0, 1);
    next();
    expect5("rst_c2", 1, 1, 1);
    #1; MRST_N = 0;
    #1;
    chk("arst_sysreq", SysReq, 0);
    chk("arst_rlabel", ReadLabel, 0);
    chk("arst_wlabel", WriteLabel, 0);
    chk("arst_stall_run", Stall, 1);
    idle();
    #1;
    chk("arst_stall_idle", Stall, 0);
    next(); MRST_N = 1;
    expect5("rst_after", 0, 0, 0);

    // randomized phase, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      next();
      I1Valid       = ($urandom_range(0, 3) != 0);
      instIsSyscall = ($urandom_range(0, 11) == 0);
      RSaddr        = 5'($urandom_range(0, 3));
      RTaddr        = 5'($urandom_range(0, 3));
      ExRDaddr      = 5'($urandom_range(0, 3));
      ExLoad        = ($urandom_range(0, 2) == 0);
      SetrValid     = ($urandom_range(0, 15) == 0);
      SetrLabel     = 1'($urandom_range(0, 1));
      SysDone       = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #1; MRST_N = 0;
        #1; MRST_N = 1;
      end
    end

    next();
    idle();
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stall_ctl.md
# decode_stall_ctl

Pipeline sequencing controller for the decode stage of the minicpu. It sits beside the decode block and drives stall/bubble control for the IF/ID and ID/EX latches. It handles three cases: load-use interlocks, the syscall drain-and-handoff sequence, and the two-cycle drain required before a SETR security-label change takes effect. It also owns the registered `ReadLabel`/`WriteLabel` state consumed by the memory and register-file label checks.

## Interface
Parameters:
- `DRAIN`, default 2: number of bubble cycles inserted before a syscall handoff or a label commit. Legal range 1–3.

Ports:
- `CLK`  in  1  — pipeline clock; all state updates on the rising edge.
- `MRST_N`  in  1  — reset; asynchronous, active-low.
- `I1Valid`  in  1  — stage-2 latch holds a valid instruction.
- `instIsSyscall`  in  1  — decode flags the stage-2 instruction as a syscall or emulated SETR.
- `RSaddr`, `RTaddr`  in  5 each  — stage-2 source register specifiers.
- `ExLoad`  in  1  — stage-3 instruction is a load.
- `ExRDaddr`  in  5  — stage-3 destination register.
- `SetrValid`  in  1  — stage-3 instruction is 32'h20000000 or 32'h20000001.
- `SetrLabel`  in  1  — bit 0 of the stage-3 SETR instruction.
- `SysDone`  in  1  — single-cycle pulse from the syscall emulator.
- `Stall`  out  1  — hold PC and the IF/ID latch.
- `Bubble`  out  1  — load a NOP into ID/EX.
- `SysReq`  out  1  — syscall service request, level.
- `ReadLabel`, `WriteLabel`  out  1 each  — current security labels, registered.

## Operation
- **State machine states:** RUN, SYS_DRAIN, SYS_REQ, SYS_REL, LBL_DRAIN.
- **Drain counter:** 2 bits, cleared on entry to SYS_DRAIN or LBL_DRAIN.
- **Pending-label register:** 1 bit.
- **Hazard term:** `hazard = I1Valid & ExLoad & (ExRDaddr != 0) & (ExRDaddr == RSaddr | ExRDaddr == RTaddr)`.

**RUN.** Events are evaluated in priority order:
1. `SetrValid`: capture `SetrLabel` into pending; go to LBL_DRAIN; `Stall`=`Bubble`=1 this cycle.
2. Else `I1Valid & instIsSyscall`: go to SYS_DRAIN; `Stall`=`Bubble`=1 this cycle.
3. Else `hazard`: `Stall`=`Bubble`=1 for this cycle only; remain in RUN.
4. Else `Stall`=`Bubble`=0.

**SYS_DRAIN.**
- `Stall`=`Bubble`=1.
- Counter increments each cycle.
- When the counter reaches `DRAIN`-1, go to SYS_REQ.

**SYS_REQ.**
- `Stall`=`Bubble`=`SysReq`=1.
- On `SysDone`, go to SYS_REL. `SysReq` deasserts in that same cycle (combinational on `SysDone`).

**SYS_REL.**
- `Stall`=`Bubble`=0, so the syscall advances.
- `instIsSyscall` and `hazard` are ignored, which prevents re-trapping the same instruction.
- `SetrValid` is handled exactly as in RUN.
- Otherwise go to RUN.

**LBL_DRAIN.**
- `Stall`=`Bubble`=1.
- Counter increments each cycle.
- At count `DRAIN`-1: `ReadLabel` and `WriteLabel` are both loaded from pending at the clock edge, and the state goes to RUN.
- `SetrValid` is ignored while in this state; stage 3 holds bubbles.

**Ignored inputs.**
- `SysDone` outside SYS_REQ is ignored.
- `SetrValid` in SYS_DRAIN and SYS_REQ is ignored; it cannot legally occur there.

**Labels.** The labels change only at a LBL_DRAIN exit or at reset.

## Timing
- **Reset.** While `MRST_N`=0, asynchronously: state=RUN, counter=0, pending=0, `ReadLabel`=`WriteLabel`=0, `SysReq`=0.
  - `Stall` and `Bubble` are 0 unless `hazard` is true, or `SetrValid` / `instIsSyscall` is asserted, in RUN.
  - Reset mid-sequence (any state) aborts it immediately. No label commit occurs.
- **Output timing.** `Stall`, `Bubble` and `SysReq` are combinational from state and inputs. Labels are registered.
- **Syscall latency.** For a syscall first seen at cycle 0 with `DRAIN`=2:
  - cycles 0–1: SYS_DRAIN;
  - `SysReq`=1 from cycle 2;
  - `SysDone` at cycle k releases (SYS_REL) at cycle k+1.
  - Minimum total stall: 3 cycles.
- **Label latency.** For SETR seen at cycle 0: bubbles in cycles 0 and 1; new labels visible at cycle 2.
- **Simultaneous events.**
  - SETR in stage 3 plus a syscall in stage 2: the label sequence runs first, then the syscall is taken in RUN.
  - Load-use hazard plus a syscall: the syscall path wins, because its drain covers the hazard.

## Test plan
- **Reset.** Assert `MRST_N`=0 mid-SYS_REQ.
  - Required: `SysReq`, `ReadLabel` and `WriteLabel` drop to 0 without waiting for `CLK`; state returns to RUN.
- **Load-use.** `ExLoad`=1, `ExRDaddr`=5, `RSaddr`=5, `I1Valid`=1.
  - Required: `Stall`=`Bubble`=1 for exactly 1 cycle.
  - Repeat with `ExRDaddr`=0. Required: no stall.
- **Syscall.** `instIsSyscall`=1 at cycle 0, `SysDone` pulse at cycle 6, `DRAIN`=2.
  - Required: `Stall`=1 for cycles 0–6; `SysReq`=1 for cycles 2–5; `Stall`=0 at cycle 7.
  - Required: no re-trap while `instIsSyscall` is still high at cycle 7.
- **Label change.** `SetrValid`=1, `SetrLabel`=1 at cycle 0.
  - Required: bubbles in cycles 0–1; `ReadLabel`=`WriteLabel`=1 from cycle 2.
  - Then 32'h20000000 in stage 3. Required: labels return to 0 two cycles later.
- **Simultaneous.** SETR in stage 3 plus a syscall in stage 2 at cycle 0.
  - Required: label commit at cycle 2; syscall drain starts at cycle 2; `SysReq` from cycle 4.
- **Spurious `SysDone`.** `SysDone` pulsed in RUN.
  - Required: no state change; `Stall`=0.
